// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Turns the one-cycle-latency read port of an upstream FIFO into a
//   first-word-fall-through valid/ready stream, using a 3-entry circular
//   skid buffer.
//
// Ports
//   rd_clk        sole clock, rising edge
//   rd_rst        synchronous active-high reset
//   fifo_empty    upstream FIFO empty flag
//   fifo_rd_en    read request to the upstream FIFO
//   fifo_rd_data  upstream read data, valid the cycle after an accepted read
//   out_valid     downstream valid
//   out_ready     downstream ready
//   out_data      downstream data (head of the buffer)
//   level         words currently held in the buffer (excludes inflight word)
//   xfer_cnt      completed downstream transfers, wraps
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [DATA_WIDTH-1:0] buffer [3];
  logic [1:0]            count;
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic                  inflight;
  logic                  xfer;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Reads are only requested while the buffer can absorb the word already
  // in flight plus the new one, so the buffer can never overflow and
  // out_ready never reaches fifo_rd_en combinationally.
  always_comb begin
    fifo_rd_en = !rd_rst && !fifo_empty &&
                 (({1'b0, count} + {2'b00, inflight}) < 3'd3);
  end

  always_comb begin
    out_valid = (count != 2'd0);
    out_data  = buffer[rd_idx];
    level     = count;
    xfer      = out_valid && out_ready;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      count    <= '0;
      inflight <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        wr_idx <= next_idx(wr_idx);
      end
      if (xfer) begin
        rd_idx   <= next_idx(rd_idx);
        xfer_cnt <= xfer_cnt + 1'b1;
      end
      case ({inflight, xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count alone decides which entries are valid.
  always_ff @(posedge rd_clk) begin
    if (inflight && !rd_rst) begin
      buffer[wr_idx] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Directed and random checks of fifo_rd_stream against an upstream FIFO
//   model and an in-order scoreboard of words accepted from that FIFO.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    level;
  logic [CW-1:0] xfer_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .xfer_cnt    (xfer_cnt)
  );

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  bit            b_inflight = 1'b0;
  int            exp_cnt = 0;
  bit            checks_on = 1'b0;
  int            n_rd = 0;
  int            n_xfer = 0;
  bit            obs_rd_en;
  bit            obs_valid;
  logic [DW-1:0] obs_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check settled
  // outputs against the model, then advance the model past the rising edge.
  task automatic tick(input bit rst, input bit ready, input bit force_empty);
    int            lvl;
    bit            exp_rd;
    bit            xfer;
    bit            rd_fire;
    logic [DW-1:0] w;
    rd_rst     = rst;
    out_ready  = ready;
    fifo_empty = force_empty || (src_q.size() == 0);
    #1;
    lvl    = exp_q.size() - int'(b_inflight);
    exp_rd = !rst && !fifo_empty && (exp_q.size() < 3);
    xfer   = !rst && (lvl != 0) && ready;
    obs_rd_en = fifo_rd_en;
    obs_valid = out_valid;
    obs_data  = out_data;
    if (checks_on) begin
      check("level", 32'(level), 32'(lvl));
      check("out_valid", 32'(out_valid), 32'(lvl != 0));
      if (lvl != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
      check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
      check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    end
    rd_fire = (fifo_rd_en === 1'b1) && !fifo_empty;
    @(posedge rd_clk);
    #1;
    if (rst) begin
      exp_q.delete();
      b_inflight   = 1'b0;
      exp_cnt      = 0;
      fifo_rd_data = DW'($urandom);
    end else begin
      if (xfer) begin
        void'(exp_q.pop_front());
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        n_xfer++;
      end
      if (rd_fire) begin
        w = src_q.pop_front();
        exp_q.push_back(w);
        fifo_rd_data = w;
        b_inflight   = 1'b1;
        n_rd++;
      end else begin
        fifo_rd_data = DW'($urandom);
        b_inflight   = 1'b0;
      end
    end
    @(negedge rd_clk);
  endtask

  initial begin
    int base_rd;
    int base_x;
    int first_valid;
    int last_valid;
    int vcount;
    bit seen;
    bit got15;
    bit got16;
    bit got17;

    rd_rst       = 1'b1;
    out_ready    = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    @(negedge rd_clk);
    tick(1'b1, 1'b0, 1'b1);
    checks_on = 1'b1;

    // Reset with data available: read request must stay gated.
    src_q = '{8'h55};
    tick(1'b1, 1'b0, 1'b0);
    check("rst_rd_en_gated", 32'(obs_rd_en), 32'(0));
    src_q.delete();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));

    // Streaming A..D with out_ready held.
    src_q       = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    first_valid = -1;
    last_valid  = -1;
    vcount      = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (i == 0) check("t1_rd_en_first", 32'(obs_rd_en), 32'(1));
      if (obs_valid) begin
        if (first_valid < 0) first_valid = i;
        last_valid = i;
        vcount++;
      end
    end
    check("t1_latency", 32'(first_valid), 32'(2));
    check("t1_last_valid", 32'(last_valid), 32'(5));
    check("t1_valid_cycles", 32'(vcount), 32'(4));
    check("t1_xfer_cnt", 32'(xfer_cnt), 32'(4));

    // Backpressure with five words waiting upstream.
    base_rd = n_rd;
    base_x  = n_xfer;
    src_q   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (i >= 3) check("t2_hold_data", 32'(obs_data), 32'(8'h10));
    end
    check("t2_reads", 32'(n_rd - base_rd), 32'(3));
    check("t2_level", 32'(level), 32'(3));
    check("t2_rd_en_off", 32'(obs_rd_en), 32'(0));
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0);
    check("t2_delivered", 32'(n_xfer - base_x), 32'(5));
    check("t2_xfer_cnt", 32'(xfer_cnt), 32'(9));

    // Upstream empty, then a single word.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      seen = seen | obs_rd_en | obs_valid | (level != 2'd0);
    end
    check("t3_idle", 32'(seen), 32'(0));
    base_rd = n_rd;
    vcount  = 0;
    src_q   = '{8'h77};
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (obs_valid) vcount++;
    end
    check("t3_reads", 32'(n_rd - base_rd), 32'(1));
    check("t3_valid_cycles", 32'(vcount), 32'(1));

    // Reset with two buffered words and one in flight.
    src_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    check("t4_level_before", 32'(level), 32'(2));
    check("t4_inflight_before", 32'(b_inflight), 32'(1));
    tick(1'b1, 1'b0, 1'b0);
    src_q.delete();
    check("t4_valid_after", 32'(out_valid), 32'(0));
    check("t4_level_after", 32'(level), 32'(0));
    check("t4_cnt_after", 32'(xfer_cnt), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      seen = seen | obs_valid;
    end
    check("t4_no_ghost", 32'(seen), 32'(0));

    // Counter wrap over 17 transfers.
    base_x = n_xfer;
    got15  = 1'b0;
    got16  = 1'b0;
    got17  = 1'b0;
    for (int i = 0; i < 17; i++) src_q.push_back(DW'(8'h30 + i));
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (!got15 && (n_xfer - base_x) == 15) begin
        check("t5_cnt15", 32'(xfer_cnt), 32'(15));
        got15 = 1'b1;
      end
      if (!got16 && (n_xfer - base_x) == 16) begin
        check("t5_cnt16", 32'(xfer_cnt), 32'(0));
        got16 = 1'b1;
      end
      if (!got17 && (n_xfer - base_x) == 17) begin
        check("t5_cnt17", 32'(xfer_cnt), 32'(1));
        got17 = 1'b1;
      end
    end
    check("t5_reached", 32'({got15, got16, got17}), 32'(3'b111));

    // Random ready/empty traffic; the per-cycle checks do the work.
    base_x = n_xfer;
    for (int i = 0; i < 10000; i++) begin
      if (src_q.size() < 4) src_q.push_back(DW'($urandom));
      tick(1'b0, bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
    end
    check("t6_progress", 32'(n_xfer - base_x > 1000), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
